serial_sum_deserializer: RTL and testbench
==========================================

Name: serial_sum_deserializer

Overview:
- Receive end of the bit-serial adder datapath.
- Collects the LSB-first sum bit stream from the serial full adder into a parallel WIDTH-bit word plus final carry.
- Presents the result on a valid/ready output handshake.
- Sits between the serial adder core and any parallel consumer, such as a register file or a result bus.

Parameters:
- WIDTH, 4, number of serial sum bits per result word (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; arms the block for a new word and clears the partial result.
- bit_valid  input  1  sum_bit/carry_bit are valid this cycle.
- sum_bit  input  1  serial sum bit, LSB first.
- carry_bit  input  1  adder carry after the current bit; only the value with the last bit is kept.
- out_ready  input  1  consumer accepts the result.
- sum_word  output  WIDTH  assembled sum.
- carry_out  output  1  final carry of the word.
- out_valid  output  1  result held and stable.
- busy  output  1  in COLLECT state.
- overrun  output  1  sticky flag; a bit arrived while no word was being collected.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, shift register 0, count 0.
  - Outputs: sum_word=0, carry_out=0, out_valid=0, busy=0, overrun=0.
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - start → COLLECT: count=0, shift register cleared, busy=1 the next cycle.
  - bit_valid without start: bit dropped, overrun set.
- COLLECT, on bit_valid:
  - Shift right, inserting sum_bit at MSB, so bit k lands at sum_word[k] after WIDTH bits.
  - count increments.
  - When count==WIDTH-1 and bit_valid: latch carry_bit into carry_out, go to HOLD, out_valid=1 the next cycle.
  - Latency is exactly 1 cycle from the last accepted bit to out_valid.
- COLLECT without bit_valid: hold; gaps between bits are allowed.
- HOLD:
  - sum_word and carry_out stay stable while out_valid=1.
  - out_valid && out_ready → IDLE, out_valid=0 the next cycle. sum_word keeps its last value.
- start in HOLD with out_ready=0: ignored. The result is not lost.
- start in HOLD with out_ready=1 in the same cycle: handshake completes and a new collection begins, going directly to COLLECT.
- start in COLLECT: restart. Partial word discarded, count=0. A bit_valid in the same cycle is treated as bit 0 of the new word.
- start and bit_valid together in IDLE: bit accepted as bit 0.
- bit_valid in HOLD: bit dropped, overrun set. overrun clears only on reset or on start.
- Count width is clog2(WIDTH); no wrap beyond WIDTH-1.
- rst_n asserted mid-word or in HOLD: immediate return to the reset values above.

Optional Feature:
- Macro: SERIAL_SUM_PARITY_EN.
- Defined:
  - Extra output parity_out (1 bit), even parity over {carry_out, sum_word}.
  - Computed incrementally as bits shift in.
  - Valid with out_valid; reset 0.
- Undefined: no port, no logic.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state enum (IDLE, COLLECT, HOLD);
  - default WIDTH constant;
  - count-width function.
- One sub-module, sipo_shift_reg: WIDTH-bit serial-in parallel-out shift register with clear and shift-enable.
- FSM and handshake logic stay in the top module.

Test Plan:
- 0101+0011 stream (bits 0,0,0,1, carry 0 on the last bit), start then 4 consecutive bit_valid → sum_word=4'b1000, carry_out=0, out_valid 1 cycle after the 4th bit.
- 1111+0001 (bits 0,0,0,0, last carry 1), out_ready held low 5 cycles → outputs stable throughout. Raise out_ready → out_valid drops next cycle.
- Gapped input: bits 1,0,1,1 with 2 idle cycles between each → sum_word=4'b1101, no overrun.
- Restart: start, 2 bits (1,1), start again, bits 0,1,0,0 → sum_word=4'b0010. Earlier bits discarded.
- bit_valid during HOLD and in IDLE without start → overrun=1, held result unchanged. Next start clears overrun.
- Assert rst_n low after 2 bits, release, start, feed 4 bits of 1 with carry 1 → sum_word=4'b1111, carry_out=1. With SERIAL_SUM_PARITY_EN, parity_out=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder datapath.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Bit count width; never below 1 so the counter is always a legal vector.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register, LSB-first stream entering at the MSB.
// A clear with shift_en set loads the incoming bit as the first bit of a new word.
module sipo_shift_reg
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= shift_en ? {din, {(WIDTH-1){1'b0}}} : '0;
        end else if (shift_en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_sum_deserializer.sv
// Collects the LSB-first serial sum stream into a parallel word plus final carry,
// presented on a valid/ready handshake. Define SERIAL_SUM_PARITY_EN for parity_out.
module serial_sum_deserializer
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_bit,
    input  logic             carry_bit,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_word,
    output logic             carry_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
`ifdef SERIAL_SUM_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg;
    logic            carry_reg;
    logic            overrun_reg;
    logic            accept_start, shift_en, last_bit, drop_bit;

    // A start in HOLD only counts when the held result is consumed in the same cycle.
    always_comb begin
        accept_start = start && ((state_reg != HOLD) || out_ready);
        shift_en     = bit_valid && (accept_start || (state_reg == COLLECT));
        last_bit     = shift_en && !accept_start && (count_reg == LAST_IDX);
        drop_bit     = bit_valid && !shift_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_start) state_next = COLLECT;
            COLLECT: begin
                if (accept_start)  state_next = COLLECT;
                else if (last_bit) state_next = HOLD;
            end
            HOLD:    if (out_ready) state_next = accept_start ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg == COLLECT);
        out_valid = (state_reg == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            carry_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept_start) begin
                count_reg   <= shift_en ? CW'(1) : '0;
                carry_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end else begin
                if (last_bit) begin
                    count_reg <= '0;
                    carry_reg <= carry_bit;
                end else if (shift_en) begin
                    count_reg <= count_reg + 1'b1;
                end
                if (drop_bit) overrun_reg <= 1'b1;
            end
        end
    end

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept_start),
        .shift_en (shift_en),
        .din      (sum_bit),
        .q        (sum_word)
    );

    assign carry_out = carry_reg;
    assign overrun   = overrun_reg;

`ifdef SERIAL_SUM_PARITY_EN
    logic parity_reg;

    // Running XOR of every accepted sum bit, folding in the carry with the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            parity_reg <= 1'b0;
        else if (accept_start) parity_reg <= shift_en & sum_bit;
        else if (shift_en)     parity_reg <= parity_reg ^ sum_bit ^ (last_bit & carry_bit);
    end

    assign parity_out = parity_reg;
`endif

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Self-checking bench for serial_sum_deserializer: word-level model plus directed vectors.
module tb_serial_sum_deserializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             bit_valid = 1'b0;
    logic             sum_bit = 1'b0;
    logic             carry_bit = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum_word;
    logic             carry_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;
`ifdef SERIAL_SUM_PARITY_EN
    logic             parity_out;
`endif

    int errors = 0;
    int checks = 0;

    serial_sum_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .sum_bit   (sum_bit),
        .carry_bit (carry_bit),
        .out_ready (out_ready),
        .sum_word  (sum_word),
        .carry_out (carry_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SERIAL_SUM_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: a queue of received bits, completed words, sticky overrun.
    int               m_bits[$];
    bit               m_collecting, m_holding, m_overrun, m_carry, m_par;
    logic [WIDTH-1:0] m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bits.delete();
            m_collecting = 0; m_holding = 0; m_overrun = 0;
            m_carry = 0; m_par = 0; m_word = '0;
        end else begin
            bit acc;
            acc = start && (!m_holding || out_ready);
            if (m_holding && out_ready) m_holding = 0;
            if (acc) begin
                m_bits.delete();
                m_collecting = 1;
                m_overrun = 0;
            end
            if (bit_valid) begin
                if (m_collecting) begin
                    m_bits.push_back(int'(sum_bit));
                    if (m_bits.size() == WIDTH) begin
                        m_word = '0;
                        for (int k = 0; k < WIDTH; k++) if (m_bits[k] != 0) m_word[k] = 1'b1;
                        m_carry = carry_bit;
                        m_par = (^m_word) ^ m_carry;
                        m_collecting = 0;
                        m_holding = 1;
                    end
                end else begin
                    m_overrun = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, well after the edge.
    always @(posedge clk) begin
        #2;
        chk("busy", busy, m_collecting);
        chk("out_valid", out_valid, m_holding);
        chk("overrun", overrun, m_overrun);
        if (m_holding) begin
            chk("sum_word", sum_word, m_word);
            chk("carry_out", carry_out, m_carry);
`ifdef SERIAL_SUM_PARITY_EN
            chk("parity_out", parity_out, m_par);
`endif
        end
    end

    task automatic cyc(input bit st, input bit bv, input bit sb, input bit cb, input bit rdy);
        @(negedge clk);
        start = st; bit_valid = bv; sum_bit = sb; carry_bit = cb; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic word(input logic [3:0] b, input bit last_c, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            cyc(0, 1, b[i], (i == WIDTH-1) ? last_c : 1'b0, 0);
            if (i < WIDTH-1) idle(gap);
        end
    endtask

    initial begin
        #12;
        chk("reset_sum_word", sum_word, 4'b0000);
        chk("reset_carry", carry_out, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(1);

        // 0101+0011: stream 0,0,0,1 carry 0
        cyc(1, 0, 0, 0, 0);
        chk("t1_busy", busy, 1);
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
        chk("t1_not_yet_valid", out_valid, 0);
        cyc(0, 1, 1, 0, 0);
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_sum", sum_word, 4'b1000);
        chk("t1_carry", carry_out, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t1_released", out_valid, 0);
        chk("t1_sum_kept", sum_word, 4'b1000);

        // 1111+0001: stream 0,0,0,0 carry 1, consumer stalls
        cyc(1, 0, 0, 0, 0);
        word(4'b0000, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc((i == 2), 0, 0, 0, 0);
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_sum", sum_word, 4'b0000);
            chk("t2_hold_carry", carry_out, 1);
        end
        cyc(0, 0, 0, 0, 1);
        chk("t2_released", out_valid, 0);

        // Gapped bits 1,0,1,1
        cyc(1, 0, 0, 0, 0);
        word(4'b1101, 1'b0, 2);
        chk("t3_sum", sum_word, 4'b1101);
        chk("t3_overrun", overrun, 0);
        // start together with out_ready: straight back to COLLECT
        cyc(1, 0, 0, 0, 1);
        chk("t3_restart_busy", busy, 1);
        chk("t3_restart_valid", out_valid, 0);

        // Restart mid-word: 1,1 discarded, then 0,1,0,0
        cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
        chk("t4_sum", sum_word, 4'b0010);
        chk("t4_valid", out_valid, 1);
        cyc(0, 0, 0, 0, 1);

        // Overrun in HOLD and in IDLE
        cyc(1, 0, 0, 0, 0);
        word(4'b0101, 1'b0, 0);
        cyc(0, 1, 1, 1, 0);
        chk("t5_overrun_hold", overrun, 1);
        chk("t5_sum_unchanged", sum_word, 4'b0101);
        chk("t5_still_valid", out_valid, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        chk("t5_overrun_idle", overrun, 1);
        cyc(1, 0, 0, 0, 0);
        chk("t5_overrun_cleared", overrun, 0);

        // Asynchronous reset mid-word
        cyc(0, 1, 1, 0, 0); cyc(0, 1, 0, 0, 0);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_sum", sum_word, 4'b0000);
        @(negedge clk); rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        word(4'b1111, 1'b1, 0);
        chk("t6_sum", sum_word, 4'b1111);
        chk("t6_carry", carry_out, 1);
`ifdef SERIAL_SUM_PARITY_EN
        chk("t6_parity", parity_out, 1);
`endif
        cyc(0, 0, 0, 0, 1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
